bs_arbiter_qos: RTL
===================

Name: bs_arbiter_qos

Overview:
- Parametrised successor of the bus generator/arbiter: a single shared bus connecting `drvrs` device FIFOs.
- Arbitrates among pending devices and pops one packet from the granted device.
- Routes the packet by the 8-bit destination ID in its MSBs, as unicast, broadcast or error-drop.
- New versus the previous generation: run-time selectable fixed-priority / round-robin mode, configurable burst length per grant, an invalid-ID error pulse, and grant/busy observability.

Parameters:
- drvrs, 4: number of devices on the bus (2..16).
- pckg_sz, 16: packet width in bits (min 9).
- broadcast, 8'hFF: destination ID meaning "all devices except source".
- burst, 1: max consecutive packets taken from one device per grant (1..15).

Ports:
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- pndng  in  drvrs: device d FIFO non-empty.
- D_pop  in  drvrs*pckg_sz: head-of-FIFO data, device d at slice [d*pckg_sz +: pckg_sz]; show-ahead, valid while pndng[d]=1.
- pop  out  drvrs: one-hot, one-cycle pulse consuming the head of device d.
- D_push  out  pckg_sz: registered bus data.
- push  out  drvrs: one-cycle write strobes; data is D_push.
- prio_mode  in  1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- grant_id  out  $clog2(drvrs): currently granted device.
- busy  out  1: high outside IDLE.
- err_id  out  1: one-cycle pulse when a packet is dropped for an invalid ID.

Behaviour:
- Reset (reset=0, async): pop=0, push=0, D_push=0, err_id=0, busy=0, grant_id=0, RR pointer=0, burst counter=0, state=IDLE. A packet already popped but not yet pushed is lost.
- Destination field: dest = packet[pckg_sz-1 -: 8].
- FSM states: IDLE, POP, PUSH.
- IDLE:
  - If |pndng: select a winner.
    - prio_mode=0: lowest set index.
    - prio_mode=1: first set index at or after the RR pointer, wrapping.
  - Register grant_id, clear the burst counter, go to POP.
  - prio_mode is sampled only here.
- POP: assert pop[grant_id] for exactly this cycle; capture D_pop slice into the internal holding register; go to PUSH.
- PUSH: D_push = captured packet; decode dest.
  - dest < drvrs: push[dest]=1. Loopback (dest==grant_id) is legal.
  - dest == broadcast: push = all ones except bit grant_id.
  - Otherwise: push=0, err_id=1; packet is dropped.
  - Then increment the burst counter.
    - If counter < burst and pndng[grant_id]=1 (sampled this cycle, after the pop): go to POP with the same grant.
    - Else: RR pointer = grant_id+1 (wrapping to 0 at drvrs); go to IDLE.
- Timing: pndng seen at edge k → pop high in cycle k+1 → push/D_push valid in cycle k+2. Throughput is 1 packet per 2 cycles inside a burst, 1 per 3 otherwise.
- pndng dropping between grant and POP: protocol violation; the block still pops and behaves the same.
- D_push holds its last value when push=0. push and pop are never asserted to the same device in the same cycle except under loopback.
- busy=0 only in IDLE.
- Simultaneous requests never produce more than one pop bit set.

Test Plan:
- Reset mid-transfer: reset low during the POP cycle → pop, push, busy drop to 0 asynchronously (before the next edge); after release, IDLE with pointer 0.
- Fixed priority: drvrs=4, prio_mode=0, pndng=4'b1010 persistent → pop[1] served repeatedly; device 3 is starved; grant_id=1.
- Round-robin: prio_mode=1, pndng=4'b1111, one packet each → pop order 0,1,2,3. Each pop is followed 1 cycle later by push[dest].
- Unicast: device 2 packet 16'h01AB → push=4'b0010, D_push=16'h01AB in cycle k+2 after pndng[2] rises at k.
- Broadcast: device 0 packet 16'hFF55 → push=4'b1110, D_push=16'hFF55.
- Error and burst:
  - Device 3 packet 16'h0712 → push=0, err_id one-cycle pulse.
  - burst=3 with device 1 holding 5 packets and device 2 pending under RR → pop[1] ×3 at 2-cycle spacing, then a grant to device 2.

Source files
------------

// File: rtl/bs_arbiter_qos.sv
// bs_arbiter_qos: shared-bus arbiter with fixed-priority or round-robin selection.
// Each grant pops up to `burst` packets from one device FIFO and routes each packet
// by its 8-bit destination ID: unicast, broadcast to all devices except the source,
// or drop with an err_id pulse.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   pndng   [drvrs]     device FIFO non-empty flags
//   D_pop   [drvrs*pw]  show-ahead FIFO heads; device d at [d*pckg_sz +: pckg_sz]
//   pop     [drvrs]     one-hot, one-cycle FIFO pop strobe
//   D_push  [pckg_sz]   bus data, holds its value between pushes
//   push    [drvrs]     per-device write strobes for D_push
//   prio_mode           0 = fixed priority (lowest index), 1 = round-robin
//   grant_id            currently granted device
//   busy                high outside IDLE
//   err_id              one-cycle pulse when a packet is dropped for an invalid ID
module bs_arbiter_qos #(
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int unsigned burst     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [pckg_sz-1:0]         D_push,
    output logic [drvrs-1:0]           push,
    input  logic                       prio_mode,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_id
);

    localparam int unsigned GW = $clog2(drvrs);
    localparam int unsigned CW = 4;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [GW-1:0]      grant_nxt;
    logic [GW-1:0]      rr_ptr, rr_nxt;
    logic [CW-1:0]      burst_cnt, cnt_nxt, cnt_inc;
    logic [drvrs-1:0]   pop_nxt, push_nxt;
    logic [pckg_sz-1:0] d_push_nxt, head;
    logic [7:0]         dest;
    logic               err_nxt, busy_nxt;
    logic [GW-1:0]      winner;
    logic               found;

    // Winner among pending devices for the selected arbitration mode
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (!prio_mode) begin
            for (int i = int'(drvrs) - 1; i >= 0; i--) begin
                if (pndng[i]) winner = GW'(i);
            end
        end else begin
            for (int i = 0; i < int'(drvrs); i++) begin
                if (!found && pndng[(int'(rr_ptr) + i) % int'(drvrs)]) begin
                    winner = GW'((int'(rr_ptr) + i) % int'(drvrs));
                    found  = 1'b1;
                end
            end
        end
    end

    // Head of the granted device's FIFO
    always_comb begin
        head = '0;
        for (int d = 0; d < int'(drvrs); d++) begin
            if (grant_id == GW'(d)) head = D_pop[d*pckg_sz +: pckg_sz];
        end
    end

    assign dest    = head[pckg_sz-1 -: 8];
    assign cnt_inc = burst_cnt + CW'(1);

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_nxt     = rr_ptr;
        cnt_nxt    = burst_cnt;
        pop_nxt    = '0;
        push_nxt   = '0;
        err_nxt    = 1'b0;
        d_push_nxt = D_push;
        case (state)
            S_IDLE: begin
                if (|pndng) begin
                    grant_nxt = winner;
                    cnt_nxt   = '0;
                    pop_nxt   = ONE << winner;
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                // Capture the popped head; routing strobes appear with it next cycle
                d_push_nxt = head;
                if (32'(dest) < drvrs) begin
                    push_nxt = ONE << dest;
                end else if (dest == broadcast) begin
                    push_nxt = ~(ONE << grant_id);
                end else begin
                    err_nxt = 1'b1;
                end
                state_nxt = S_PUSH;
            end
            S_PUSH: begin
                cnt_nxt = cnt_inc;
                // pndng here already reflects the pop just completed
                if ((32'(cnt_inc) < burst) && pndng[grant_id]) begin
                    pop_nxt   = ONE << grant_id;
                    state_nxt = S_POP;
                end else begin
                    rr_nxt    = (grant_id == GW'(drvrs - 1)) ? '0 : grant_id + GW'(1);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            pop       <= '0;
            push      <= '0;
            D_push    <= '0;
            err_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
            pop       <= pop_nxt;
            push      <= push_nxt;
            D_push    <= d_push_nxt;
            err_id    <= err_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
